// File: rtl/axi_sram_rd_arbiter.sv
// -----------------------------------------------------------------------------
// axi_sram_rd_arbiter
//
// Shares the single read port of the SRAM read model between two masters:
// master 0 is the instruction fetch unit (IFU) and master 1 is the
// load/store unit (LSU). The channel style is AXI-lite: a read-address
// (AR) handshake followed by a read-data (R) handshake.
//
// Arbitration is round-robin, with only one transaction in flight at a time.
// The grant is locked from the master's AR handshake until the matching
// R handshake. The accepted address is registered. Read data is not buffered:
// it passes straight from the SRAM to the granted master.
//
// Ports
//   aclk, areset             clock (rising edge), asynchronous active-high reset
//   m0_ar*, m0_r*            IFU read-address / read-data channel
//   m1_ar*, m1_r*            LSU read-address / read-data channel
//   s_ar*, s_r*              channel towards the SRAM read model
//   busy                     a transaction is held (accepted, R not yet done)
//   grant                    owner of the current or most recent transaction
//                            (0 = IFU, 1 = LSU)
// -----------------------------------------------------------------------------
module axi_sram_rd_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              aclk,
  input  logic              areset,
  // IFU (master 0)
  input  logic [ADDR_W-1:0] m0_araddr,
  input  logic              m0_arvalid,
  output logic              m0_arready,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_rvalid,
  input  logic              m0_rready,
  // LSU (master 1)
  input  logic [ADDR_W-1:0] m1_araddr,
  input  logic              m1_arvalid,
  output logic              m1_arready,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_rvalid,
  input  logic              m1_rready,
  // SRAM read model
  output logic [ADDR_W-1:0] s_araddr,
  output logic              s_arvalid,
  input  logic              s_arready,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic              s_rvalid,
  output logic              s_rready,
  // status
  output logic              busy,
  output logic              grant
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic              grant_q, grant_d;
  logic              last_q,  last_d;

  logic              win_vld;
  logic              win_id;

  // Round-robin pick. Under contention the master that did not own the
  // previous transaction wins. last_q resets to 1, so the IFU wins the
  // first contention after reset.
  always_comb begin
    win_vld = m0_arvalid | m1_arvalid;
    win_id  = (m0_arvalid & m1_arvalid) ? ~last_q : m1_arvalid;
  end

  // ---- state register ------------------------------------------------------
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  // ---- next state and outputs ----------------------------------------------
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    grant_d    = grant_q;
    last_d     = last_q;
    m0_arready = 1'b0;
    m1_arready = 1'b0;
    m0_rvalid  = 1'b0;
    m1_rvalid  = 1'b0;
    m0_rdata   = '0;
    m1_rdata   = '0;
    s_arvalid  = 1'b0;
    s_rready   = 1'b0;

    unique case (state_q)
      IDLE: begin
        // arready comes from the combinational pick. It is gated by areset
        // so that no master sees an accept while the block is held in reset.
        if (win_vld && !areset) begin
          m0_arready = ~win_id;
          m1_arready = win_id;
          addr_d     = win_id ? m1_araddr : m0_araddr;
          grant_d    = win_id;
          state_d    = ADDR;
        end
      end

      ADDR: begin
        // addr_q is frozen here, so s_araddr stays stable while the SRAM stalls.
        s_arvalid = 1'b1;
        if (s_arready) begin
          state_d = DATA;
        end
      end

      DATA: begin
        // Pure passthrough. The non-granted master sees zeros, and a low
        // rready from the owner back-pressures the SRAM directly.
        if (grant_q) begin
          m1_rvalid = s_rvalid;
          m1_rdata  = s_rdata;
          s_rready  = m1_rready;
        end else begin
          m0_rvalid = s_rvalid;
          m0_rdata  = s_rdata;
          s_rready  = m0_rready;
        end
        if (s_rvalid && s_rready) begin
          last_d  = grant_q;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // s_rvalid outside DATA is a protocol error. It never reaches a master
  // because only DATA routes it.
  assign s_araddr = addr_q;
  assign busy     = (state_q != IDLE);
  assign grant    = grant_q;

endmodule

// File: tb/tb_axi_sram_rd_arbiter.sv
// -----------------------------------------------------------------------------
// tb_axi_sram_rd_arbiter
//
// Self-checking bench for axi_sram_rd_arbiter.
//
// The reference model is transaction level. It tracks only:
//   - whether a transaction is held,
//   - its owner and address,
//   - whether its address has already reached the SRAM,
//   - who owned the previous transaction.
// Every cycle, the expected outputs are derived from that state and from the
// round-robin rule.
//
// The SRAM is modelled as an address-to-data function. Its AR-ready stall
// and R latency are either programmed or random. Masters raise requests from
// directed values or at random, and keep at most one request in flight.
// -----------------------------------------------------------------------------
module tb_axi_sram_rd_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              aclk = 1'b0;
  logic              areset;
  logic [ADDR_W-1:0] maddr [2];
  logic              mv    [2];
  logic              mrr   [2];
  logic              m0_arready, m1_arready, m0_rvalid, m1_rvalid;
  logic [DATA_W-1:0] m0_rdata, m1_rdata;
  logic [ADDR_W-1:0] s_araddr;
  logic              s_arvalid, s_arready, s_rvalid, s_rready;
  logic [DATA_W-1:0] s_rdata;
  logic              busy, grant;

  always #5 aclk = ~aclk;

  axi_sram_rd_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .aclk       (aclk),
    .areset     (areset),
    .m0_araddr  (maddr[0]),
    .m0_arvalid (mv[0]),
    .m0_arready (m0_arready),
    .m0_rdata   (m0_rdata),
    .m0_rvalid  (m0_rvalid),
    .m0_rready  (mrr[0]),
    .m1_araddr  (maddr[1]),
    .m1_arvalid (mv[1]),
    .m1_arready (m1_arready),
    .m1_rdata   (m1_rdata),
    .m1_rvalid  (m1_rvalid),
    .m1_rready  (mrr[1]),
    .s_araddr   (s_araddr),
    .s_arvalid  (s_arvalid),
    .s_arready  (s_arready),
    .s_rdata    (s_rdata),
    .s_rvalid   (s_rvalid),
    .s_rready   (s_rready),
    .busy       (busy),
    .grant      (grant)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  bit          mb;      // transaction held
  bit          mi;      // its address has been taken by the SRAM
  bit          mo;      // owner
  bit          mg;      // grant output
  bit          ml;      // owner of previous completed transaction
  logic [31:0] ma;      // registered address

  // environment state
  int          m_prob  [2];
  int          rr_prob [2];
  logic [31:0] m_next  [2];
  bit          m_out   [2];
  bit          rand_addr, rand_sram;
  int          cfg_stall, cfg_lat;
  int          ar_hold, r_cnt;
  bit          r_pending;
  logic [31:0] r_addr;
  int          cyc;
  int          acc_log[$];
  int          acc_cyc[$];
  int          rhs_cyc[$];

  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == 32'h8000_0000) return 32'h0000_0413;
    return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock cycle. It is entered about 2ns after a rising edge, once the
  // inputs are settled. Outputs are checked at the falling edge. The model
  // advances, the edge is taken, and then the environment reacts to the
  // handshakes it saw.
  task automatic tick();
    int          win;
    logic        e_rv0, e_rv1;
    bit          acc0, acc1, arwait, arhs, rhs, rh0, rh1;
    logic [31:0] ar_a;
    #3;
    win = -1;
    if (!mb) begin
      if (mv[0] && mv[1]) win = ml ? 0 : 1;
      else if (mv[0])     win = 0;
      else if (mv[1])     win = 1;
    end
    e_rv0 = mb && mi && !mo && s_rvalid;
    e_rv1 = mb && mi &&  mo && s_rvalid;
    chk("busy",       64'(busy),       64'(mb));
    chk("grant",      64'(grant),      64'(mg));
    chk("m0_arready", 64'(m0_arready), 64'(win == 0));
    chk("m1_arready", 64'(m1_arready), 64'(win == 1));
    chk("s_arvalid",  64'(s_arvalid),  64'(mb && !mi));
    chk("s_araddr",   64'(s_araddr),   64'(ma));
    chk("m0_rvalid",  64'(m0_rvalid),  64'(e_rv0));
    chk("m1_rvalid",  64'(m1_rvalid),  64'(e_rv1));
    chk("m0_rdata",   64'(m0_rdata),   e_rv0 ? 64'(mem(ma)) : 64'd0);
    chk("m1_rdata",   64'(m1_rdata),   e_rv1 ? 64'(mem(ma)) : 64'd0);
    chk("s_rready",   64'(s_rready),   (mb && mi) ? 64'(mrr[mo]) : 64'd0);
    chk("sram_rvalid_phase", 64'(s_rvalid && !(mb && mi)), 64'd0);

    acc0   = mv[0] && m0_arready;
    acc1   = mv[1] && m1_arready;
    arwait = s_arvalid && !s_arready && (ar_hold > 0);
    arhs   = s_arvalid && s_arready;
    ar_a   = s_araddr;
    rhs    = s_rvalid && s_rready;
    rh0    = m0_rvalid && mrr[0];
    rh1    = m1_rvalid && mrr[1];
    if (acc0) begin acc_log.push_back(0); acc_cyc.push_back(cyc); end
    if (acc1) begin acc_log.push_back(1); acc_cyc.push_back(cyc); end
    if (rhs)  rhs_cyc.push_back(cyc);

    if (!mb) begin
      if (win >= 0) begin
        mb = 1'b1; mo = win[0]; mg = win[0]; ma = maddr[win[0]]; mi = 1'b0;
      end
    end else if (!mi) begin
      if (s_arready) mi = 1'b1;
    end else if (s_rvalid && mrr[mo]) begin
      mb = 1'b0; ml = mo;
    end

    @(posedge aclk);
    #1;
    cyc++;

    for (int i = 0; i < 2; i++) begin
      if ((i == 0 && acc0) || (i == 1 && acc1)) begin mv[i] = 1'b0; m_out[i] = 1'b1; end
      if ((i == 0 && rh0) || (i == 1 && rh1)) m_out[i] = 1'b0;
      if (!mv[i] && !m_out[i] && int'($urandom_range(99)) < m_prob[i]) begin
        mv[i]    = 1'b1;
        maddr[i] = rand_addr ? ($urandom & 32'hFFFF_FFFC) : m_next[i];
        m_next[i] += 4;
      end
      mrr[i] = int'($urandom_range(99)) < rr_prob[i];
    end

    if (arwait) ar_hold--;
    if (acc0 || acc1) ar_hold = rand_sram ? int'($urandom_range(3)) : cfg_stall;
    s_arready = (ar_hold == 0);
    if (rhs) r_pending = 1'b0;
    if (arhs) begin
      r_pending = 1'b1;
      r_cnt     = rand_sram ? int'($urandom_range(4)) : cfg_lat;
      r_addr    = ar_a;
    end
    s_rvalid = 1'b0;
    s_rdata  = '0;
    if (r_pending) begin
      if (r_cnt == 0) begin
        s_rvalid = 1'b1;
        s_rdata  = mem(r_addr);
      end else begin
        r_cnt--;
      end
    end
    #1;
  endtask

  // Reset is asserted mid-cycle. The optional checks run before any clock
  // edge. Release follows the next rising edge, with model and SRAM reset too.
  task automatic do_reset(input bit chk_now);
    areset = 1'b1;
    #1;
    if (chk_now) begin
      chk("rst_m0_arready", 64'(m0_arready), 64'd0);
      chk("rst_m1_arready", 64'(m1_arready), 64'd0);
      chk("rst_m0_rvalid",  64'(m0_rvalid),  64'd0);
      chk("rst_m1_rvalid",  64'(m1_rvalid),  64'd0);
      chk("rst_m0_rdata",   64'(m0_rdata),   64'd0);
      chk("rst_m1_rdata",   64'(m1_rdata),   64'd0);
      chk("rst_s_arvalid",  64'(s_arvalid),  64'd0);
      chk("rst_s_rready",   64'(s_rready),   64'd0);
      chk("rst_s_araddr",   64'(s_araddr),   64'd0);
      chk("rst_busy",       64'(busy),       64'd0);
      chk("rst_grant",      64'(grant),      64'd0);
    end
    @(posedge aclk);
    #1;
    for (int i = 0; i < 2; i++) begin
      mv[i] = 1'b0; maddr[i] = '0; mrr[i] = 1'b1; m_out[i] = 1'b0;
      m_prob[i] = 0; rr_prob[i] = 100;
    end
    ar_hold = 0; r_cnt = 0; r_pending = 1'b0; r_addr = '0;
    s_arready = 1'b1; s_rvalid = 1'b0; s_rdata = '0;
    mb = 1'b0; mi = 1'b0; mo = 1'b0; mg = 1'b0; ml = 1'b1; ma = '0;
    areset = 1'b0;
    #1;
  endtask

  task automatic drain();
    int n;
    m_prob[0] = 0; m_prob[1] = 0; rr_prob[0] = 100; rr_prob[1] = 100;
    for (n = 0; n < 200 && (busy || mv[0] || mv[1]); n++) tick();
    chk("drain_timeout", 64'(busy || mv[0] || mv[1]), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n, n_ar;
    logic [31:0] bp_data;
    areset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      mv[i] = 1'b0; maddr[i] = '0; mrr[i] = 1'b1; m_prob[i] = 0; rr_prob[i] = 100;
      m_next[i] = '0; m_out[i] = 1'b0;
    end
    s_arready = 1'b1; s_rvalid = 1'b0; s_rdata = '0;
    rand_addr = 1'b0; rand_sram = 1'b0; cfg_stall = 0; cfg_lat = 1;
    cyc = 0;
    do_reset(1'b1);

    // IFU alone
    mv[0] = 1'b1; maddr[0] = 32'h8000_0000;
    #1;
    chk("ifu_alone_accept", 64'(m0_arready), 64'd1);
    tick();
    for (n = 0; n < 20 && !m0_rvalid; n++) tick();
    chk("ifu_alone_rvalid", 64'(m0_rvalid), 64'd1);
    chk("ifu_alone_rdata",  64'(m0_rdata),  64'h0000_0413);
    chk("ifu_alone_m1_rv",  64'(m1_rvalid), 64'd0);
    drain();

    // contention after reset, then strict alternation
    do_reset(1'b0);
    acc_log.delete(); acc_cyc.delete(); rhs_cyc.delete();
    m_next[0] = 32'h8000_0004; m_next[1] = 32'h8000_1000;
    mv[0] = 1'b1; maddr[0] = m_next[0]; m_next[0] += 4;
    mv[1] = 1'b1; maddr[1] = m_next[1]; m_next[1] += 4;
    m_prob[0] = 100; m_prob[1] = 100;
    #1;
    chk("contend_ifu_first", 64'(m0_arready), 64'd1);
    chk("contend_lsu_wait",  64'(m1_arready), 64'd0);
    for (n = 0; n < 300 && acc_log.size() < 8; n++) tick();
    chk("contend_accepts", 64'(acc_log.size()), 64'd8);
    for (int k = 0; k < 8 && k < acc_log.size(); k++)
      chk($sformatf("contend_alt_%0d", k), 64'(acc_log[k]), 64'(k % 2));
    chk("lsu_after_ifu_r",
        64'(acc_cyc.size() > 1 && rhs_cyc.size() > 0 && acc_cyc[1] == rhs_cyc[0] + 1), 64'd1);
    drain();

    // backpressure from the IFU
    cfg_lat = 0;
    mv[0] = 1'b1; maddr[0] = 32'h8000_0010; rr_prob[0] = 0; mrr[0] = 1'b0;
    for (n = 0; n < 20 && !m0_rvalid; n++) tick();
    chk("bp_rvalid_seen", 64'(m0_rvalid), 64'd1);
    bp_data = m0_rdata;
    chk("bp_data", 64'(bp_data), 64'(mem(32'h8000_0010)));
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("bp_hold_rvalid", 64'(m0_rvalid), 64'd1);
      chk("bp_hold_data",   64'(m0_rdata),  64'(bp_data));
      chk("bp_s_rready",    64'(s_rready),  64'd0);
      chk("bp_busy",        64'(busy),      64'd1);
    end
    rr_prob[0] = 100; mrr[0] = 1'b1;
    tick();
    chk("bp_done", 64'(busy), 64'd0);
    drain();

    // SRAM slow to accept the address
    cfg_stall = 2; cfg_lat = 1;
    mv[0] = 1'b1; maddr[0] = 32'h8000_0020;
    tick();
    mv[1] = 1'b1; maddr[1] = 32'h8000_1100;
    n_ar = 0;
    for (n = 0; n < 10 && s_arvalid; n++) begin
      chk("slow_addr_stable", 64'(s_araddr), 64'h8000_0020);
      chk("slow_no_arready",  64'(m0_arready || m1_arready), 64'd0);
      n_ar++;
      tick();
    end
    chk("slow_arvalid_cycles", 64'(n_ar), 64'd3);
    drain();
    cfg_stall = 0;

    // late LSU request while the IFU is in its data phase
    cfg_lat = 3;
    mv[0] = 1'b1; maddr[0] = 32'h8000_0030;
    tick(); tick();
    chk("late_in_data", 64'(busy && !s_arvalid), 64'd1);
    mv[1] = 1'b1; maddr[1] = 32'h8000_2000;
    for (n = 0; n < 20 && !(m0_rvalid && mrr[0]); n++) begin
      chk("late_m1_blocked", 64'(m1_arready), 64'd0);
      tick();
    end
    tick();
    chk("late_m1_accept", 64'(m1_arready), 64'd1);
    tick();
    chk("late_m1_addr", 64'(s_araddr), 64'h8000_2000);
    drain();

    // asynchronous reset during the data phase
    cfg_lat = 6;
    mv[0] = 1'b1; maddr[0] = 32'h8000_0040;
    tick(); tick();
    chk("arst_in_data", 64'(busy && !s_arvalid), 64'd1);
    mv[1] = 1'b1; maddr[1] = 32'h8000_1200;
    tick();
    do_reset(1'b1);
    cfg_lat = 1;
    mv[0] = 1'b1; maddr[0] = 32'h8000_0044;
    mv[1] = 1'b1; maddr[1] = 32'h8000_1204;
    #1;
    chk("arst_ifu_wins", 64'(m0_arready), 64'd1);
    chk("arst_lsu_waits", 64'(m1_arready), 64'd0);
    tick();
    drain();

    // random traffic
    acc_log.delete();
    rand_addr = 1'b1; rand_sram = 1'b1;
    m_prob[0] = 40; m_prob[1] = 40; rr_prob[0] = 70; rr_prob[1] = 70;
    for (int k = 0; k < 2000; k++) tick();
    drain();
    chk("random_activity", 64'(acc_log.size() > 50), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
